// File: rtl/sort_ctrl.sv
// sort_ctrl: sequential 4-element bubble sorter, one compare-swap per clock
// Ports: clk, rst_n (async active-low); start, x0..x3 (operands captured on accept);
//        s0..s3 (element registers, sorted after done), busy, done (1-cycle pulse),
//        swap_cnt (swaps in current/last sort).
// Build option: define SORT_DESCEND_EN for descending order (s0 largest).
module sort_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x0,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] x3,
    output logic [N-1:0] s0,
    output logic [N-1:0] s1,
    output logic [N-1:0] s2,
    output logic [N-1:0] s3,
    output logic         busy,
    output logic         done,
    output logic [2:0]   swap_cnt
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t       state;
    logic [1:0]   pass, idx;
    logic [N-1:0] s [4];
    logic [N-1:0] a, b;
    logic         swp, last;
    assign s0 = s[0];
    assign s1 = s[1];
    assign s2 = s[2];
    assign s3 = s[3];
    // pass p compares idx 0..2-p, so the last pair of a pass is idx == 2-pass
    always_comb begin
        a    = s[idx];
        b    = s[idx + 2'd1];
`ifdef SORT_DESCEND_EN
        swp  = a < b;
`else
        swp  = a > b;
`endif
        last = idx == 2'd2 - pass;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            for (int i = 0; i < 4; i++) s[i] <= '0;
            swap_cnt <= '0;
            pass     <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    s[0]     <= x0;
                    s[1]     <= x1;
                    s[2]     <= x2;
                    s[3]     <= x3;
                    swap_cnt <= '0;
                    pass     <= '0;
                    idx      <= '0;
                    busy     <= 1'b1;
                    state    <= CMP;
                end
                CMP: begin
                    if (swp) begin
                        s[idx]        <= b;
                        s[idx + 2'd1] <= a;
                        swap_cnt      <= swap_cnt + 3'd1;
                    end
                    if (last) begin
                        idx <= '0;
                        if (pass == 2'd2) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else pass <= pass + 2'd1;
                    end else idx <= idx + 2'd1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
